vram_write_arbiter: RTL and testbench
=====================================

// Module: vram_write_arbiter
// PURPOSE
//  Shares the single write port of the 128x32 video RAM between two pixel
//  requesters and a full-screen fill engine. Converts (x,y,color) pixel writes
//  on the 20x15 tile grid into read-modify-write word updates (4 pixels/word,
//  5 words/row). Sits between the requesters and the RAM address/data/we port.
//  The VGA scan-out read port is untouched.
// PARAMETERS
//  COLS           20  grid width in tiles
//  ROWS           15  grid height in tiles
//  WORDS_PER_ROW   5  32-bit words per grid row (COLS/4)
//  ADDR_W          7  RAM word address width
// PORTS
//  clk          in   1   single system clock
//  reset        in   1   synchronous, active-high
//  req0_valid   in   1   requester 0 has a pixel write
//  req0_x       in   5   tile column 0..COLS-1
//  req0_y       in   4   tile row 0..ROWS-1
//  req0_color   in   8   pixel byte, {2'bxx,R[1:0],G[1:0],B[1:0]}
//  req0_ready   out  1   1-cycle pulse: request 0 accepted this edge
//  req1_*       -    -   identical set for requester 1
//  fill_start   in   1   pulse: fill every word with {4{fill_color}}
//  fill_color   in   8   fill byte, sampled with fill_start
//  busy         out  1   state != IDLE or fill pending
//  fill_done    out  1   1-cycle pulse after last fill word written
//  drop         out  1   1-cycle pulse: accepted request had x/y out of range
//  mem_addr     out  ADDR_W  RAM word address
//  mem_wdata    out  32  RAM write data (top drives data bus when mem_we=1)
//  mem_rdata    in   32  RAM read data, combinational from mem_addr
//  mem_we       out  1   RAM write enable
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer favours req0, fill pending cleared; all
//    outputs 0 (ready, busy, fill_done, drop, mem_we, mem_addr, mem_wdata).
//  - Reset mid-operation aborts at the next edge; the word in flight is not
//    written. A half-filled frame stays half-filled.
//  - Address: addr = (x>>2) + y*WORDS_PER_ROW. Byte lane by x[1:0]:
//    0->[31:24], 1->[23:16], 2->[15:8], 3->[7:0].
//  - FSM states: IDLE, READ, WRITE, FILL.
//    IDLE: if fill pending -> FILL, addr=0. Else grant one valid requester
//      round-robin (last-granted loses ties), pulse its ready, latch x/y/color.
//      In range -> READ. Out of range -> pulse drop, stay IDLE, no write.
//    READ: mem_addr=latched addr, mem_we=0. Register rdata with the selected
//      lane replaced by color -> WRITE.
//    WRITE: mem_addr held, mem_wdata=merged word, mem_we=1 for exactly 1
//      cycle -> IDLE.
//    FILL: mem_we=1, mem_wdata={4{color}}, addr 0..COLS*ROWS/4-1 (0..74),
//      one word per cycle. After the word at 74 -> IDLE, pulse fill_done.
//  - Per pixel: 3 cycles (accept, READ, WRITE). Back-to-back stream: one
//    pixel per 3 cycles. Fill: 75 cycles of mem_we.
//  - fill_start in any state sets fill pending and latches fill_color. Fill
//    has priority over pixel requests at the next IDLE. fill_start during FILL
//    is ignored. A pixel transaction already in READ/WRITE completes first.
//  - Requester holds valid and payload until it sees ready. ready never
//    asserts outside IDLE. Only one ready per cycle.
//  - mem_we=0 in IDLE and READ. Addresses 75..127 are never written.
// TESTING
//  1 Reset, then req0 x=5 y=2 color=8'h3F, RAM[11]=32'hAABBCCDD -> ready0
//    pulse; after 2 more cycles RAM[11]=32'hAA3FCCDD; mem_we high 1 cycle.
//  2 req0 and req1 valid continuously -> grants alternate 0,1,0,1; each
//    ready spaced 3 cycles apart; both payloads land in RAM.
//  3 fill_start color=8'h30 from idle -> 75 consecutive we cycles, addr
//    0..74; every word 32'h30303030; fill_done pulses once; RAM[75] unchanged.
//  4 fill_start while req1 is in READ -> req1 WRITE completes, then FILL;
//    fill overwrites req1's pixel; pending pixel req0 waits until after fill.
//  5 req0 x=20 y=0 (out of range) -> ready0 and drop pulse same cycle; no
//    mem_we; req1 serviced next cycle.
//  6 Reset asserted at fill word 40 -> mem_we=0 from next cycle; words 0..39
//    filled, 40..74 unchanged; busy=0; later requests work normally.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// Write-port arbiter for the 128x32 tile video RAM: two round-robin pixel
// requesters doing read-modify-write byte updates, plus a whole-frame fill engine.
module vram_write_arbiter #(
  parameter int COLS          = 20,
  parameter int ROWS          = 15,
  parameter int WORDS_PER_ROW = 5,
  parameter int ADDR_W        = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [4:0]        req0_x,
  input  logic [3:0]        req0_y,
  input  logic [7:0]        req0_color,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_x,
  input  logic [3:0]        req1_y,
  input  logic [7:0]        req1_color,
  output logic              req1_ready,
  input  logic              fill_start,
  input  logic [7:0]        fill_color,
  output logic              busy,
  output logic              fill_done,
  output logic              drop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we
);

  localparam int LAST_WORD = (COLS * ROWS / 4) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FILL  = 2'd3
  } state_t;

  state_t              state_r;
  logic                pri1_r;
  logic                fill_pend_r;
  logic [7:0]          fill_color_r;
  logic [1:0]          lane_r;
  logic [7:0]          color_r;

  logic                v0_s;
  logic                v1_s;
  logic                gnt_any_s;
  logic                gnt1_s;
  logic [4:0]          sel_x_s;
  logic [3:0]          sel_y_s;
  logic [7:0]          sel_color_s;
  logic                in_range_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                fill_latch_s;

  // Replace one byte lane of a RAM word; lane 0 is the leftmost pixel (MSB).
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  color);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[31:24] = color;
      2'd1:    res[23:16] = color;
      2'd2:    res[15:8]  = color;
      2'd3:    res[7:0]   = color;
      default: res = word;
    endcase
    return res;
  endfunction

  assign busy = (state_r != IDLE) || fill_pend_r;

  // Round-robin grant and address decode for the requester that would win now.
  always_comb begin
    // A requester whose ready is showing is still dropping its old request.
    v0_s      = req0_valid && !req0_ready;
    v1_s      = req1_valid && !req1_ready;
    gnt_any_s = v0_s || v1_s;
    if (v0_s && v1_s) begin
      gnt1_s = pri1_r;
    end else if (v1_s) begin
      gnt1_s = 1'b1;
    end else begin
      gnt1_s = 1'b0;
    end
    if (gnt1_s) begin
      sel_x_s     = req1_x;
      sel_y_s     = req1_y;
      sel_color_s = req1_color;
    end else begin
      sel_x_s     = req0_x;
      sel_y_s     = req0_y;
      sel_color_s = req0_color;
    end
    in_range_s   = (sel_x_s < 5'(COLS)) && (sel_y_s < 4'(ROWS));
    addr_s       = ADDR_W'(sel_x_s >> 2) + ADDR_W'(sel_y_s) * ADDR_W'(WORDS_PER_ROW);
    fill_latch_s = fill_start && ((state_r == READ) || (state_r == WRITE) ||
                                  ((state_r == IDLE) && !fill_pend_r));
  end

  // Main FSM with registered RAM port and handshake pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pri1_r       <= 1'b0;
      fill_pend_r  <= 1'b0;
      fill_color_r <= 8'h00;
      lane_r       <= 2'd0;
      color_r      <= 8'h00;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      fill_done    <= 1'b0;
      drop         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0000_0000;
      mem_we       <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      fill_done  <= 1'b0;
      drop       <= 1'b0;
      if (fill_latch_s) begin
        fill_pend_r  <= 1'b1;
        fill_color_r <= fill_color;
      end
      case (state_r)
        IDLE: begin
          if (fill_pend_r) begin
            fill_pend_r <= 1'b0;
            state_r     <= FILL;
            mem_addr    <= '0;
            mem_wdata   <= {4{fill_color_r}};
            mem_we      <= 1'b1;
          end else if (gnt_any_s) begin
            if (gnt1_s) begin
              req1_ready <= 1'b1;
            end else begin
              req0_ready <= 1'b1;
            end
            pri1_r <= !gnt1_s;
            if (in_range_s) begin
              state_r  <= READ;
              mem_addr <= addr_s;
              lane_r   <= sel_x_s[1:0];
              color_r  <= sel_color_s;
            end else begin
              drop <= 1'b1;
            end
          end else begin
            mem_we <= 1'b0;
          end
        end
        READ: begin
          mem_wdata <= merge_lane(mem_rdata, lane_r, color_r);
          mem_we    <= 1'b1;
          state_r   <= WRITE;
        end
        WRITE: begin
          mem_we  <= 1'b0;
          state_r <= IDLE;
        end
        FILL: begin
          if (mem_addr == ADDR_W'(LAST_WORD)) begin
            mem_we    <= 1'b0;
            fill_done <= 1'b1;
            state_r   <= IDLE;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        default: begin
          mem_we  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter with a behavioural 128x32 RAM model.
module tb_vram_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_x = 5'd0, req1_x = 5'd0;
  logic [3:0]  req0_y = 4'd0, req1_y = 4'd0;
  logic [7:0]  req0_color = 8'h00, req1_color = 8'h00;
  logic        req0_ready, req1_ready;
  logic        fill_start = 1'b0;
  logic [7:0]  fill_color = 8'h00;
  logic        busy, fill_done, drop;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] ram [0:127];
  logic        bd_init = 1'b0, bd_we = 1'b0, cnt_clr = 1'b0;
  logic [6:0]  bd_addr = 7'd0;
  logic [31:0] bd_data = 32'h0;
  int          we_cnt = 0;
  int          checks_n = 0, fail_n = 0;

  always #5 clk = ~clk;

  vram_write_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
    .req0_color(req0_color), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
    .req1_color(req1_color), .req1_ready(req1_ready),
    .fill_start(fill_start), .fill_color(fill_color),
    .busy(busy), .fill_done(fill_done), .drop(drop),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // RAM model with backdoor preload plus a write-enable counter.
  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < 128; i++) ram[i] <= pat(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (bd_we) ram[bd_addr] <= bd_data;
    end
    if (cnt_clr) we_cnt <= 0;
    else if (mem_we) we_cnt <= we_cnt + 1;
  end
  assign mem_rdata = ram[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; bd_init = 1'b1; cnt_clr = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; fill_start = 1'b0;
    step(); step();
    reset = 1'b0; bd_init = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    int gseq [8];
    int gcyc [8];
    int ng, n0, n1, two_rdy, we_n, addr_err, data_err, done_n, first_we, last_we, fd, r0;
    bit found;

    // 1: reset state, then a single read-modify-write
    do_reset();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'h0);
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    check_eq("rst_ready1", 32'(req1_ready), 32'd0);
    check_eq("rst_fill_done", 32'(fill_done), 32'd0);
    check_eq("rst_drop", 32'(drop), 32'd0);
    bd_we = 1'b1; bd_addr = 7'd11; bd_data = 32'hAABB_CCDD;
    step();
    bd_we = 1'b0;
    req0_x = 5'd5; req0_y = 4'd2; req0_color = 8'h3F; req0_valid = 1'b1;
    step();
    check_eq("t1_ready0", 32'(req0_ready), 32'd1);
    check_eq("t1_read_addr", 32'(mem_addr), 32'd11);
    check_eq("t1_read_we", 32'(mem_we), 32'd0);
    req0_valid = 1'b0;
    step();
    check_eq("t1_write_we", 32'(mem_we), 32'd1);
    check_eq("t1_write_data", mem_wdata, 32'hAA3F_CCDD);
    step();
    check_eq("t1_we_drop", 32'(mem_we), 32'd0);
    check_eq("t1_ram11", ram[11], 32'hAA3F_CCDD);
    check_eq("t1_we_cnt", 32'(we_cnt), 32'd1);

    // 2: both requesters streaming -> alternating grants 3 cycles apart
    do_reset();
    req0_x = 5'd0; req0_y = 4'd0; req0_color = 8'h11; req0_valid = 1'b1;
    req1_x = 5'd3; req1_y = 4'd1; req1_color = 8'h22; req1_valid = 1'b1;
    ng = 0; n0 = 0; n1 = 0; two_rdy = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step();
      if (req0_ready && req1_ready) two_rdy++;
      if (req0_ready && ng < 8) begin
        gseq[ng] = 0; gcyc[ng] = c; ng++; n0++;
        if (n0 == 1) begin req0_x = 5'd1; req0_color = 8'h33; end
        else req0_valid = 1'b0;
      end
      if (req1_ready && ng < 8) begin
        gseq[ng] = 1; gcyc[ng] = c; ng++; n1++;
        if (n1 == 1) begin req1_x = 5'd2; req1_color = 8'h44; end
        else req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("t2_grants", 32'(ng), 32'd4);
    check_eq("t2_one_ready", 32'(two_rdy), 32'd0);
    for (int k = 0; k < 4; k++) check_eq("t2_gseq", 32'(gseq[k]), 32'(k % 2));
    for (int k = 1; k < 4; k++) check_eq("t2_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    step(); step(); step(); step();
    check_eq("t2_ram0", ram[0], 32'h1133_0000);
    check_eq("t2_ram5", ram[5], 32'hC0DE_4422);
    check_eq("t2_we_cnt", 32'(we_cnt), 32'd4);

    // 3: full-screen fill from idle
    do_reset();
    fill_color = 8'h30; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    check_eq("t3_busy", 32'(busy), 32'd1);
    we_n = 0; addr_err = 0; data_err = 0; done_n = 0; first_we = -1; last_we = -1;
    for (int c = 0; c < 100; c++) begin
      if (mem_we) begin
        if (32'(mem_addr) != 32'(we_n)) addr_err++;
        if (mem_wdata != 32'h3030_3030) data_err++;
        if (first_we < 0) first_we = c;
        last_we = c;
        we_n++;
      end
      if (fill_done) done_n++;
      step();
    end
    check_eq("t3_we_cycles", 32'(we_n), 32'd75);
    check_eq("t3_consecutive", 32'(last_we - first_we + 1), 32'd75);
    check_eq("t3_addr_seq", 32'(addr_err), 32'd0);
    check_eq("t3_data", 32'(data_err), 32'd0);
    check_eq("t3_fill_done", 32'(done_n), 32'd1);
    check_eq("t3_ram0", ram[0], 32'h3030_3030);
    check_eq("t3_ram74", ram[74], 32'h3030_3030);
    check_eq("t3_ram75", ram[75], pat(75));
    check_eq("t3_idle_busy", 32'(busy), 32'd0);

    // 4: fill requested while req1 is mid-transaction
    do_reset();
    req1_x = 5'd4; req1_y = 4'd0; req1_color = 8'h77; req1_valid = 1'b1;
    step();
    check_eq("t4_ready1", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;
    fill_color = 8'h5A; fill_start = 1'b1;
    req0_x = 5'd6; req0_y = 4'd0; req0_color = 8'h99; req0_valid = 1'b1;
    step();
    fill_start = 1'b0;
    check_eq("t4_px_we", 32'(mem_we), 32'd1);
    check_eq("t4_px_addr", 32'(mem_addr), 32'd1);
    check_eq("t4_px_data", mem_wdata, 32'h77DE_0001);
    fd = -1; r0 = -1;
    for (int c = 0; c < 150 && r0 < 0; c++) begin
      step();
      if (fill_done) fd = c;
      if (req0_ready) begin r0 = c; req0_valid = 1'b0; end
    end
    req0_valid = 1'b0;
    check_eq("t4_fill_done_seen", 32'(fd >= 0), 32'd1);
    check_eq("t4_req0_after_fill", 32'(r0 - fd), 32'd1);
    step(); step(); step();
    check_eq("t4_ram1", ram[1], 32'h5A5A_995A);
    check_eq("t4_ram2", ram[2], 32'h5A5A_5A5A);
    check_eq("t4_we_cnt", 32'(we_cnt), 32'd77);

    // 5: out-of-range request is dropped, other requester follows
    do_reset();
    req0_x = 5'd20; req0_y = 4'd0; req0_color = 8'h55; req0_valid = 1'b1;
    req1_x = 5'd1;  req1_y = 4'd0; req1_color = 8'h66; req1_valid = 1'b1;
    step();
    check_eq("t5_ready0", 32'(req0_ready), 32'd1);
    check_eq("t5_drop", 32'(drop), 32'd1);
    check_eq("t5_no_we", 32'(mem_we), 32'd0);
    req0_valid = 1'b0;
    step();
    check_eq("t5_ready1", 32'(req1_ready), 32'd1);
    check_eq("t5_drop_pulse", 32'(drop), 32'd0);
    req1_valid = 1'b0;
    step(); step();
    check_eq("t5_ram0", ram[0], 32'hC066_0000);
    check_eq("t5_we_cnt", 32'(we_cnt), 32'd1);

    // 6: reset during fill leaves a half-filled frame
    do_reset();
    fill_color = 8'hE7; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (mem_we && mem_addr == 7'd39) found = 1'b1;
      else step();
    end
    check_eq("t6_reached_39", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    check_eq("t6_we_off", 32'(mem_we), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    check_eq("t6_ram39", ram[39], 32'hE7E7_E7E7);
    check_eq("t6_ram40", ram[40], pat(40));
    check_eq("t6_we_cnt", 32'(we_cnt), 32'd40);
    req0_x = 5'd19; req0_y = 4'd14; req0_color = 8'h12; req0_valid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (req0_ready) found = 1'b1;
    end
    req0_valid = 1'b0;
    check_eq("t6_post_ready", 32'(found), 32'd1);
    step(); step(); step();
    check_eq("t6_ram74", ram[74], 32'hC0DE_0012);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
